rgb_pattern_led: RTL and testbench
==================================

Name: rgb_pattern_led

Overview:
Parametrised multi-channel LED pattern driver, and the successor to the fixed blinker behind the board RGB LED pins. Each channel gets a PWM brightness level. All channels share one pattern mode: off, solid, blink or breathe. The pattern is stepped by a prescaled tick derived from the system clock. New configuration is double-buffered and applied only on a PWM frame boundary, so outputs never glitch.

Parameters:
CHANNELS, 3, number of LED outputs (R,G,B by default)
PWM_BITS, 8, PWM counter and level/envelope width; frame = 2^PWM_BITS clk cycles
CLK_HZ, 24000000, system clock frequency
TICK_HZ, 1000, pattern step rate; DIV = CLK_HZ/TICK_HZ, must be an integer and >= 1
ACTIVE_LOW, 0, 1 inverts every led output bit (for sink-driven LED pins)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
cfg_load  in  1  one-cycle strobe; captures mode/level/period into the shadow registers
cfg_mode  in  2  0=OFF, 1=SOLID, 2=BLINK, 3=BREATHE
cfg_level  in  CHANNELS*PWM_BITS  per-channel brightness; channel n uses bits [n*PWM_BITS +: PWM_BITS]
cfg_period  in  16  ticks per blink half-period or per breathe step; 0 is treated as 1
cfg_pending  out  1  shadow captured but not yet applied
led  out  CHANNELS  registered LED drive
env  out  PWM_BITS  current breathe envelope, for observation

Behaviour:
- Reset (clk edge with rst=1): pwm_cnt=0, presc=0, step_cnt=0, active mode=OFF, level=0, period=1, blink_phase=1, env=0, dir=up, cfg_pending=0, env=0, led = ACTIVE_LOW ? all 1s : all 0s. rst has priority over cfg_load in the same cycle.
- Prescaler: presc counts 0..DIV-1 and then wraps. tick=1 for exactly one cycle when presc==DIV-1.
- PWM: pwm_cnt increments every clk and wraps 2^PWM_BITS-1 -> 0. frame_end = (pwm_cnt == all-ones).
- Config capture: cfg_load=1 copies the inputs into the shadow and sets cfg_pending=1. A second load while pending overwrites the shadow; the last load wins.
- Config apply: on a cycle with frame_end && cfg_pending, the shadow is copied to the active registers and cfg_pending clears.
  - Apply also resets step_cnt=0, blink_phase=1, env=0, dir=up.
  - If cfg_load coincides with apply, the new values go to the shadow and cfg_pending stays 1.
- Pattern step: occurs on tick, except in the apply cycle.
  - step_cnt increments; when step_cnt == period_eff-1 it wraps to 0 and an event fires.
  - BLINK event: toggle blink_phase.
  - BREATHE event: env +1 if dir=up, else -1.
    - Reaching all-ones sets dir=down; reaching 0 sets dir=up.
    - env never wraps.
  - OFF/SOLID: step_cnt runs, events ignored; env and blink_phase hold.
- Effective duty per channel:
  - OFF = 0.
  - SOLID = level.
  - BLINK = blink_phase ? level : 0.
  - BREATHE = (level*env) >> PWM_BITS, using a full 2*PWM_BITS product and keeping the upper half.
- Output: on_n = (pwm_cnt < duty_n); led_n <= on_n ^ ACTIVE_LOW, registered with 1 clk latency from pwm_cnt.
  - duty 0 gives never-on.
  - duty all-ones gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.

Test Plan:
(Bench: PWM_BITS=4, CLK_HZ=16, TICK_HZ=1, so DIV=16 and a tick once per frame.)
- Reset, hold 64 clk -> led=000, env=0, cfg_pending=0. With ACTIVE_LOW=1 -> led=111.
- Load SOLID with levels R=4, G=0, B=15 mid-frame -> cfg_pending=1 until the first frame_end, then clears. Each subsequent 16-cycle frame: R high 4 cycles, G never high, B high 15 cycles.
- Load BLINK, level R=15, period=2 -> R shows PWM for 2 frames (32 clk), is dark for 32 clk, and repeats. Load with period=0 behaves as period=1: toggles every frame.
- Load BREATHE, R=15, period=1 -> env climbs 0..15 over 15 ticks, then falls to 0 over 15 ticks (30-tick cycle), no wrap. At env=15 R duty=14; at env=8 R duty=7.
- Two cfg_load pulses within one frame (SOLID R=3, then SOLID R=9) -> only R=9 is applied at frame_end. A load in the apply cycle leaves cfg_pending=1 and applies one frame later.
- Assert rst mid-BREATHE with env=9 -> next cycle: env=0, mode OFF, led inactive, cfg_pending=0; a pending shadow is discarded.

Source files
------------

// File: rtl/rgb_pattern_led_if.sv
// rgb_pattern_led_if: configuration and status bundle for rgb_pattern_led.
//   cfg_load    : one-cycle strobe that captures mode/level/period into the shadow
//   cfg_mode    : 0=OFF, 1=SOLID, 2=BLINK, 3=BREATHE
//   cfg_level   : per-channel brightness, channel n at [n*PWM_BITS +: PWM_BITS]
//   cfg_period  : ticks per blink half-period / breathe step (0 behaves as 1)
//   cfg_pending : shadow captured but not yet applied
//   led         : registered LED drive
//   env         : current breathe envelope
// master = configuring side, slave = the LED driver.
interface rgb_pattern_led_if #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
);
  logic                         cfg_load;
  logic [1:0]                   cfg_mode;
  logic [CHANNELS*PWM_BITS-1:0] cfg_level;
  logic [15:0]                  cfg_period;
  logic                         cfg_pending;
  logic [CHANNELS-1:0]          led;
  logic [PWM_BITS-1:0]          env;

  modport master (
    output cfg_load, cfg_mode, cfg_level, cfg_period,
    input  cfg_pending, led, env
  );

  modport slave (
    input  cfg_load, cfg_mode, cfg_level, cfg_period,
    output cfg_pending, led, env
  );
endinterface

// File: rtl/rgb_pattern_led.sv
// rgb_pattern_led: multi-channel PWM LED pattern driver.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : rgb_pattern_led_if.slave (config inputs, cfg_pending/led/env outputs)
// Configuration is double-buffered: cfg_load fills a shadow, which is copied to
// the active registers only on the last cycle of a PWM frame.
//
// Pattern modes:
//   mode         | meaning
//   MODE_OFF     | all channels dark
//   MODE_SOLID   | duty = level
//   MODE_BLINK   | duty = level while blink_phase=1, else 0
//   MODE_BREATHE | duty = (level*env) >> PWM_BITS, env ramps 0..max..0
module rgb_pattern_led #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int CLK_HZ     = 24000000,
  parameter int TICK_HZ    = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  rgb_pattern_led_if.slave  bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]       PRESC_MAX = PW'(DIV - 1);
  localparam logic [PWM_BITS-1:0] ENV_MAX   = {PWM_BITS{1'b1}};
  localparam logic                INV       = (ACTIVE_LOW != 0);
  localparam int LW = CHANNELS * PWM_BITS;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  mode_e               sh_mode_q, sh_mode_d, mode_q, mode_d;
  logic [LW-1:0]       sh_level_q, sh_level_d, level_q, level_d;
  logic [15:0]         sh_period_q, sh_period_d, period_q, period_d;
  logic                pending_q, pending_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] env_q, env_d;
  logic                dir_down_q, dir_down_d;
  logic [CHANNELS-1:0] led_q, led_d;

  logic                  tick, frame_end, apply, evt;
  logic [PWM_BITS-1:0]   lvl, duty;
  logic [2*PWM_BITS-1:0] prod;

  always_comb begin
    presc_d       = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    sh_mode_d     = sh_mode_q;
    sh_level_d    = sh_level_q;
    sh_period_d   = sh_period_q;
    pending_d     = pending_q;
    mode_d        = mode_q;
    level_d       = level_q;
    period_d      = period_q;
    step_cnt_d    = step_cnt_q;
    blink_phase_d = blink_phase_q;
    env_d         = env_q;
    dir_down_d    = dir_down_q;
    evt           = 1'b0;

    tick      = (presc_q == PRESC_MAX);
    frame_end = (pwm_cnt_q == ENV_MAX);
    apply     = frame_end && pending_q;

    if (apply) begin
      mode_d        = sh_mode_q;
      level_d       = sh_level_q;
      period_d      = sh_period_q;
      pending_d     = 1'b0;
      step_cnt_d    = '0;
      blink_phase_d = 1'b1;
      env_d         = '0;
      dir_down_d    = 1'b0;
    end else if (tick) begin
      // period_q is already the effective period (never 0)
      if (step_cnt_q == period_q - 16'd1) begin
        step_cnt_d = '0;
        evt        = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
      if (evt && mode_q == MODE_BLINK) begin
        blink_phase_d = ~blink_phase_q;
      end
      // envelope saturates at both ends and reverses direction there
      if (evt && mode_q == MODE_BREATHE) begin
        if (!dir_down_q) begin
          if (env_q != ENV_MAX) env_d = env_q + 1'b1;
          if (env_q >= ENV_MAX - 1'b1) dir_down_d = 1'b1;
        end else begin
          if (env_q != '0) env_d = env_q - 1'b1;
          if (env_q <= PWM_BITS'(1)) dir_down_d = 1'b0;
        end
      end
    end

    // placed after apply so a load in the apply cycle keeps pending set
    if (bus.cfg_load) begin
      sh_mode_d   = mode_e'(bus.cfg_mode);
      sh_level_d  = bus.cfg_level;
      sh_period_d = (bus.cfg_period == 16'd0) ? 16'd1 : bus.cfg_period;
      pending_d   = 1'b1;
    end
  end

  always_comb begin
    led_d = '0;
    lvl   = '0;
    duty  = '0;
    prod  = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      lvl  = level_q[n*PWM_BITS +: PWM_BITS];
      prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, env_q};
      case (mode_q)
        MODE_SOLID:   duty = lvl;
        MODE_BLINK:   duty = blink_phase_q ? lvl : '0;
        MODE_BREATHE: duty = prod[2*PWM_BITS-1:PWM_BITS];
        default:      duty = '0;
      endcase
      led_d[n] = (pwm_cnt_q < duty) ^ INV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      sh_mode_q     <= MODE_OFF;
      sh_level_q    <= '0;
      sh_period_q   <= 16'd1;
      pending_q     <= 1'b0;
      mode_q        <= MODE_OFF;
      level_q       <= '0;
      period_q      <= 16'd1;
      step_cnt_q    <= '0;
      blink_phase_q <= 1'b1;
      env_q         <= '0;
      dir_down_q    <= 1'b0;
      led_q         <= {CHANNELS{INV}};
    end else begin
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      sh_mode_q     <= sh_mode_d;
      sh_level_q    <= sh_level_d;
      sh_period_q   <= sh_period_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      level_q       <= level_d;
      period_q      <= period_d;
      step_cnt_q    <= step_cnt_d;
      blink_phase_q <= blink_phase_d;
      env_q         <= env_d;
      dir_down_q    <= dir_down_d;
      led_q         <= led_d;
    end
  end

  assign bus.cfg_pending = pending_q;
  assign bus.led         = led_q;
  assign bus.env         = env_q;
endmodule

// File: tb/tb_rgb_pattern_led.sv
module tb_rgb_pattern_led;
  localparam int CH = 3;
  localparam int PB = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   t;          // posedges since reset release
  int   cnt  [3];
  int   acnt [3];

  rgb_pattern_led_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();
  rgb_pattern_led_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus_al ();

  assign bus_al.cfg_load   = bus.cfg_load;
  assign bus_al.cfg_mode   = bus.cfg_mode;
  assign bus_al.cfg_level  = bus.cfg_level;
  assign bus_al.cfg_period = bus.cfg_period;

  rgb_pattern_led #(.CHANNELS(CH), .PWM_BITS(PB), .CLK_HZ(16), .TICK_HZ(1),
                    .ACTIVE_LOW(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  rgb_pattern_led #(.CHANNELS(CH), .PWM_BITS(PB), .CLK_HZ(16), .TICK_HZ(1),
                    .ACTIVE_LOW(1)) dut_al (.clk(clk), .rst(rst), .bus(bus_al));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_phase(input int ph);
    int n = 0;
    while ((t % 16) != ph && n < 40) begin
      @(negedge clk);
      n++;
    end
    if ((t % 16) != ph) begin
      checks++;
      errors++;
      $error("FAIL phase_timeout observed %0d expected %0d", t % 16, ph);
    end
  endtask

  task automatic load(input logic [1:0] mode, input logic [11:0] lvl, input logic [15:0] per);
    bus.cfg_load   = 1'b1;
    bus.cfg_mode   = mode;
    bus.cfg_level  = lvl;
    bus.cfg_period = per;
    @(negedge clk);
    bus.cfg_load   = 1'b0;
  endtask

  // counts high cycles per channel over the next 16-cycle frame
  task automatic measure_frame();
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      acnt[i] = 0;
    end
    repeat (16) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cnt[i]  += int'(bus.led[i]);
        acnt[i] += int'(bus_al.led[i]);
      end
    end
  endtask

  initial begin
    int exp_blink2 [5];
    int exp_blink0 [4];
    int exp_env;
    exp_blink2 = '{15, 15, 0, 0, 15};
    exp_blink0 = '{15, 0, 15, 0};

    rst = 1'b1;
    bus.cfg_load   = 1'b0;
    bus.cfg_mode   = 2'd0;
    bus.cfg_level  = '0;
    bus.cfg_period = '0;
    step(64);
    check("reset_led", bus.led, 3'b000);
    check("reset_env", bus.env, 0);
    check("reset_pending", bus.cfg_pending, 0);
    check("reset_led_al", bus_al.led, 3'b111);
    rst = 1'b0;

    // SOLID R=4 G=0 B=15, loaded mid-frame
    goto_phase(5);
    load(2'd1, {4'd15, 4'd0, 4'd4}, 16'd1);
    check("solid_pending_set", bus.cfg_pending, 1);
    goto_phase(15);
    check("solid_pending_before_end", bus.cfg_pending, 1);
    step(1);
    check("solid_pending_cleared", bus.cfg_pending, 0);
    for (int f = 0; f < 2; f++) begin
      measure_frame();
      check("solid_r", cnt[0], 4);
      check("solid_g", cnt[1], 0);
      check("solid_b", cnt[2], 15);
    end
    check("solid_al_r", acnt[0], 12);
    check("solid_al_g", acnt[1], 16);
    check("solid_al_b", acnt[2], 1);

    // BLINK R=15 period=2: two frames lit, two dark
    goto_phase(5);
    load(2'd2, {4'd0, 4'd0, 4'd15}, 16'd2);
    goto_phase(0);
    for (int f = 0; f < 5; f++) begin
      measure_frame();
      check("blink2_r", cnt[0], exp_blink2[f]);
    end
    check("blink2_g", cnt[1], 0);

    // BLINK with period 0 toggles every frame
    goto_phase(5);
    load(2'd2, {4'd0, 4'd0, 4'd15}, 16'd0);
    goto_phase(0);
    for (int f = 0; f < 4; f++) begin
      measure_frame();
      check("blink0_r", cnt[0], exp_blink0[f]);
    end

    // BREATHE R=15 period=1: env 0..15..0..1 over 32 frames
    goto_phase(5);
    load(2'd3, {4'd0, 4'd0, 4'd15}, 16'd1);
    goto_phase(0);
    for (int k = 0; k < 32; k++) begin
      exp_env = (k <= 15) ? k : ((k <= 30) ? (30 - k) : (k - 30));
      check("breathe_env", bus.env, exp_env);
      measure_frame();
      if (k == 0)  check("breathe_r_env0", cnt[0], 0);
      if (k == 8)  check("breathe_r_env8", cnt[0], 7);
      if (k == 15) check("breathe_r_env15", cnt[0], 14);
    end

    // two loads in one frame: last wins
    goto_phase(3);
    load(2'd1, {4'd0, 4'd0, 4'd3}, 16'd1);
    goto_phase(8);
    load(2'd1, {4'd0, 4'd0, 4'd9}, 16'd1);
    goto_phase(0);
    measure_frame();
    check("double_load_r", cnt[0], 9);

    // load coinciding with the apply cycle
    goto_phase(5);
    load(2'd1, {4'd0, 4'd0, 4'd2}, 16'd1);
    goto_phase(15);
    load(2'd1, {4'd0, 4'd0, 4'd12}, 16'd1);
    check("apply_load_pending", bus.cfg_pending, 1);
    measure_frame();
    check("apply_load_first_r", cnt[0], 2);
    check("apply_load_pending_clr", bus.cfg_pending, 0);
    measure_frame();
    check("apply_load_second_r", cnt[0], 12);

    // reset during BREATHE at env=9 with a pending shadow
    goto_phase(5);
    load(2'd3, {4'd0, 4'd0, 4'd15}, 16'd1);
    goto_phase(0);
    step(9 * 16);
    check("pre_reset_env", bus.env, 9);
    goto_phase(5);
    load(2'd1, {4'd0, 4'd0, 4'd5}, 16'd1);
    check("pre_reset_pending", bus.cfg_pending, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_env", bus.env, 0);
    check("rst_pending", bus.cfg_pending, 0);
    check("rst_led", bus.led, 3'b000);
    check("rst_led_al", bus_al.led, 3'b111);
    goto_phase(0);
    for (int f = 0; f < 2; f++) begin
      measure_frame();
      check("post_rst_r", cnt[0], 0);
      check("post_rst_gb", cnt[1] + cnt[2], 0);
      check("post_rst_al_r", acnt[0], 16);
    end
    check("post_rst_pending", bus.cfg_pending, 0);
    check("post_rst_env", bus.env, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
